// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares the single-port data memory between the pipeline MEM stage (CPU port)
// and a debug/loader port (DBG port). Each access owns the memory bus for
// MEM_LATENCY cycles after a one-cycle grant decision in IDLE. The CPU has
// priority. A starvation counter forces a DBG grant after STARVE_LIMIT
// consecutive CPU grants while dbg_req is pending.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   cpu_read, cpu_write  MEM stage load/store request (level, held while stalled)
//   cpu_addr, cpu_wdata  CPU access address and store data
//   cpu_rdata            load data to MEM_WB (live in done cycle, held after)
//   cpu_stall            freezes PC, IF_ID, ID_EX, EX_MEM while access pending
//   dbg_req              debug request, held until dbg_ack
//   dbg_we               debug direction: 1 = write, 0 = read
//   dbg_addr, dbg_wdata  debug address and write data
//   dbg_rdata            debug read data, registered at completion
//   dbg_ack              one-cycle completion pulse
//   mem_en, mem_we       memory enable / write enable (registered)
//   mem_addr, mem_wdata  memory address / write data (registered, held stable)
//   mem_rdata            memory read data, valid in the final access cycle
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [DATA_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_ZERO   = {STV_W{1'b0}};
    localparam logic [STV_W-1:0] STV_ONE    = STV_W'(1'b1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_ACC = 2'd1,
        ST_DBG_ACC = 2'd2
    } state_t;

    state_t                  state_r,      state_s;
    logic [CNT_W-1:0]        cnt_r,        cnt_s;
    logic [STV_W-1:0]        starve_cnt_r, starve_cnt_s;
    logic                    mem_en_r,     mem_en_s;
    logic                    mem_we_r,     mem_we_s;
    logic [DATA_WIDTH-1:0]   mem_addr_r,   mem_addr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_r,  mem_wdata_s;
    logic [DATA_WIDTH-1:0]   cpu_rdata_r,  cpu_rdata_s;
    logic [DATA_WIDTH-1:0]   dbg_rdata_r,  dbg_rdata_s;
    logic                    dbg_ack_r,    dbg_ack_s;

    logic                    cpu_req_s;
    logic                    acc_done_s;
    logic                    cpu_done_s;
    logic                    grant_cpu_s;
    logic                    grant_dbg_s;

    // Request decode and access-completion flags.
    always_comb begin
        cpu_req_s  = cpu_read | cpu_write;
        acc_done_s = (cnt_r == CNT_ZERO);
        cpu_done_s = (state_r == ST_CPU_ACC) && acc_done_s;
    end

    // Grant decision; only taken in IDLE. A starved DBG beats the CPU.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_dbg_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (dbg_req && (starve_cnt_r == STARVE_MAX)) begin
                grant_dbg_s = 1'b1;
            end else if (cpu_req_s) begin
                grant_cpu_s = 1'b1;
            end else if (dbg_req) begin
                grant_dbg_s = 1'b1;
            end else begin
                grant_cpu_s = 1'b0;
                grant_dbg_s = 1'b0;
            end
        end else begin
            grant_cpu_s = 1'b0;
            grant_dbg_s = 1'b0;
        end
    end

    // Starvation counter: counts CPU wins against a waiting DBG, saturating.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        if (!dbg_req) begin
            starve_cnt_s = STV_ZERO;
        end else if (grant_dbg_s) begin
            starve_cnt_s = STV_ZERO;
        end else if (grant_cpu_s && (starve_cnt_r < STARVE_MAX)) begin
            starve_cnt_s = starve_cnt_r + STV_ONE;
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // Next-state logic and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        mem_en_s    = mem_en_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        cpu_rdata_s = cpu_rdata_r;
        dbg_rdata_s = dbg_rdata_r;
        dbg_ack_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (grant_dbg_s) begin
                    state_s     = ST_DBG_ACC;
                    cnt_s       = CNT_LOAD;
                    mem_en_s    = 1'b1;
                    mem_we_s    = dbg_we;
                    mem_addr_s  = dbg_addr;
                    mem_wdata_s = dbg_wdata;
                end else if (grant_cpu_s) begin
                    // Read and write together is a store.
                    state_s     = ST_CPU_ACC;
                    cnt_s       = CNT_LOAD;
                    mem_en_s    = 1'b1;
                    mem_we_s    = cpu_write;
                    mem_addr_s  = cpu_addr;
                    mem_wdata_s = cpu_wdata;
                end else begin
                    mem_en_s = 1'b0;
                    mem_we_s = 1'b0;
                end
            end

            ST_CPU_ACC: begin
                if (acc_done_s) begin
                    state_s     = ST_IDLE;
                    mem_en_s    = 1'b0;
                    mem_we_s    = 1'b0;
                    cpu_rdata_s = mem_rdata;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end

            ST_DBG_ACC: begin
                if (acc_done_s) begin
                    state_s   = ST_IDLE;
                    mem_en_s  = 1'b0;
                    mem_we_s  = 1'b0;
                    dbg_ack_s = 1'b1;
                    if (!mem_we_r) begin
                        dbg_rdata_s = mem_rdata;
                    end else begin
                        dbg_rdata_s = dbg_rdata_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end

            default: begin
                state_s  = ST_IDLE;
                cnt_s    = CNT_ZERO;
                mem_en_s = 1'b0;
                mem_we_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            starve_cnt_r <= STV_ZERO;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= DATA_ZERO;
            mem_wdata_r  <= DATA_ZERO;
            cpu_rdata_r  <= DATA_ZERO;
            dbg_rdata_r  <= DATA_ZERO;
            dbg_ack_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            starve_cnt_r <= starve_cnt_s;
            mem_en_r     <= mem_en_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            cpu_rdata_r  <= cpu_rdata_s;
            dbg_rdata_r  <= dbg_rdata_s;
            dbg_ack_r    <= dbg_ack_s;
        end
    end

    // The stall must drop in the done cycle so the pipeline advances on the
    // same edge that retires the access; it is suppressed during reset.
    assign cpu_stall = reset ? 1'b0 : (cpu_req_s & ~cpu_done_s);
    // Load data is forwarded live in the done cycle, then held.
    assign cpu_rdata = cpu_done_s ? mem_rdata : cpu_rdata_r;

    assign dbg_rdata = dbg_rdata_r;
    assign dbg_ack   = dbg_ack_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Scoreboarded bench for data_mem_arbiter. Stimulus tasks push the expected
// response (data from a flat reference memory, allowed latency window) into
// per-port queues; a monitor pops and compares on every CPU completion
// (request high, stall low) and every dbg_ack. The memory array behind the
// arbiter presents read data only in the final access cycle.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    localparam int DW = 64;
    localparam int L  = 2;
    localparam int SL = 4;
    localparam logic [DW-1:0] JUNK = 64'hBADC_0FFE_E0DD_F00D;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_read, cpu_write;
    logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we;
    logic [DW-1:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic          dbg_ack;
    logic          mem_en, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

    data_mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    int cyc = 0;
    // Cycle counter used to time-stamp requests and completions.
    always @(posedge clock) cyc <= cyc + 1;

    // Reference memory image (what software expects memory to hold).
    logic [DW-1:0] ref_mem [0:255];

    // Physical memory behind the arbiter.
    logic [DW-1:0] env_mem [0:255];
    int            acc_cyc = 0;
    bit            mem_init_done = 1'b0;

    assign mem_rdata = (mem_en && acc_cyc == L - 1) ? env_mem[mem_addr[7:0]] : JUNK;

    // Memory array: preload once, then commit writes in the final access cycle.
    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= ref_mem[i];
            mem_init_done <= 1'b1;
        end else if (mem_en && mem_we && acc_cyc == L - 1) begin
            env_mem[mem_addr[7:0]] <= mem_wdata;
        end
        if (mem_en) acc_cyc <= acc_cyc + 1;
        else        acc_cyc <= 0;
    end

    typedef struct {
        bit            is_read;
        logic [DW-1:0] data;
        int            issue_cyc;
        int            lat_lo;
        int            lat_hi;
    } exp_t;

    exp_t cpu_q[$];
    exp_t dbg_q[$];

    int checks = 0;
    int errors = 0;
    bit dbg_pending = 1'b0;

    task automatic chk64(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
        end
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk1({nm, "_mem_en"}, mem_en, 1'b0);
        chk1({nm, "_mem_we"}, mem_we, 1'b0);
        chk64({nm, "_mem_addr"}, mem_addr, 64'd0);
        chk64({nm, "_mem_wdata"}, mem_wdata, 64'd0);
        chk64({nm, "_cpu_rdata"}, cpu_rdata, 64'd0);
        chk64({nm, "_dbg_rdata"}, dbg_rdata, 64'd0);
        chk1({nm, "_dbg_ack"}, dbg_ack, 1'b0);
        chk1({nm, "_cpu_stall"}, cpu_stall, 1'b0);
    endtask

    // Monitor: bus stability during an access, and scoreboard pops.
    task automatic monitor();
        logic          we_l;
        logic [DW-1:0] addr_l, wdata_l;
        exp_t          e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (mem_en) begin
                    if (acc_cyc == 0) begin
                        we_l = mem_we; addr_l = mem_addr; wdata_l = mem_wdata;
                    end else begin
                        chk1("bus_we_stable", mem_we, we_l);
                        chk64("bus_addr_stable", mem_addr, addr_l);
                        chk64("bus_wdata_stable", mem_wdata, wdata_l);
                    end
                end
                if ((cpu_read || cpu_write) && !cpu_stall) begin
                    if (cpu_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cpu_unexpected: completion with no pending request (cycle %0d)", cyc);
                    end else begin
                        e = cpu_q.pop_front();
                        if (e.is_read) chk64("cpu_rdata", cpu_rdata, e.data);
                        chk_rng("cpu_latency", cyc - e.issue_cyc, e.lat_lo, e.lat_hi);
                    end
                end
                if (dbg_ack) begin
                    if (dbg_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL dbg_unexpected: dbg_ack with no pending request (cycle %0d)", cyc);
                    end else begin
                        e = dbg_q.pop_front();
                        if (e.is_read) chk64("dbg_rdata", dbg_rdata, e.data);
                        chk_rng("dbg_latency", cyc - e.issue_cyc, e.lat_lo, e.lat_hi);
                    end
                end
            end
        end
    endtask

    // Present a CPU request and record its expected outcome.
    task automatic cpu_issue(input bit wr, input bit rd, input logic [7:0] a,
                             input logic [DW-1:0] d, input int lo, input int hi);
        exp_t e;
        @(posedge clock); #1;
        cpu_write = wr; cpu_read = rd;
        cpu_addr = {56'd0, a}; cpu_wdata = d;
        e.is_read = !wr; e.issue_cyc = cyc; e.lat_lo = lo; e.lat_hi = hi;
        if (wr) begin
            ref_mem[a] = d;
            e.data = d;
        end else begin
            e.data = ref_mem[a];
        end
        cpu_q.push_back(e);
    endtask

    // Wait (bounded) for the stall to drop, i.e. the CPU done cycle.
    task automatic cpu_wait();
        int n = 0;
        forever begin
            @(negedge clock);
            if (!cpu_stall) break;
            n++;
            if (n > 40) begin
                checks++; errors++;
                $display("FAIL cpu_timeout: stall never released (cycle %0d)", cyc);
                break;
            end
        end
    endtask

    task automatic cpu_op(input bit wr, input bit rd, input logic [7:0] a,
                          input logic [DW-1:0] d, input int lo, input int hi);
        cpu_issue(wr, rd, a, d, lo, hi);
        cpu_wait();
    endtask

    task automatic cpu_idle();
        @(posedge clock); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    // Debug access: hold dbg_req until dbg_ack is seen (bounded).
    task automatic dbg_op(input bit we, input logic [7:0] a, input logic [DW-1:0] d,
                          input int lo, input int hi);
        exp_t e;
        int   n = 0;
        @(posedge clock); #1;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = {56'd0, a}; dbg_wdata = d;
        e.is_read = !we; e.issue_cyc = cyc; e.lat_lo = lo; e.lat_hi = hi;
        if (we) begin
            ref_mem[a] = d;
            e.data = d;
        end else begin
            e.data = ref_mem[a];
        end
        dbg_q.push_back(e);
        dbg_pending = 1'b1;
        forever begin
            @(posedge clock); #1;
            if (dbg_ack) begin
                dbg_req = 1'b0; dbg_pending = 1'b0;
                break;
            end
            n++;
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL dbg_timeout: no dbg_ack (cycle %0d)", cyc);
                dbg_req = 1'b0; dbg_pending = 1'b0;
                break;
            end
        end
    endtask

    // Main stimulus.
    initial begin
        int t0;
        int cpu_grants;
        int lat5 [6];

        for (int i = 0; i < 256; i++) ref_mem[i] = {$urandom, $urandom};
        ref_mem[8'h10] = 64'hDEAD;
        ref_mem[8'h30] = 64'h7;

        reset = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 64'd0; cpu_wdata = 64'd0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 64'd0; dbg_wdata = 64'd0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_outputs_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk_outputs_zero("idle");

        // Single load: stall in cycles 0-1, mem_en in cycles 1-2.
        cpu_issue(1'b0, 1'b1, 8'h10, 64'd0, L, L);
        @(negedge clock);
        chk1("t1_stall_c0", cpu_stall, 1'b1);
        chk1("t1_mem_en_c0", mem_en, 1'b0);
        @(negedge clock);
        chk1("t1_stall_c1", cpu_stall, 1'b1);
        chk1("t1_mem_en_c1", mem_en, 1'b1);
        @(negedge clock);
        chk1("t1_stall_c2", cpu_stall, 1'b0);
        chk1("t1_mem_en_c2", mem_en, 1'b1);
        cpu_idle();
        @(negedge clock);
        chk1("t1_mem_en_c3", mem_en, 1'b0);
        chk64("t1_rdata_held", cpu_rdata, 64'hDEAD);

        // Store then load of the same address, back to back.
        t0 = cyc + 1;
        cpu_op(1'b1, 1'b0, 8'h20, 64'h55, L, L);
        cpu_op(1'b0, 1'b1, 8'h20, 64'd0, L, L);
        chk_rng("t2_total_cycles", cyc - t0 + 1, 2 * (L + 1), 2 * (L + 1));
        cpu_idle();

        // Debug read with CPU idle.
        dbg_op(1'b0, 8'h30, 64'd0, L + 1, L + 1);
        repeat (2) @(posedge clock);

        // Starvation: continuous loads with dbg_req held.
        cpu_grants = 0;
        lat5 = '{L, L, L, L, 2 * L + 1, L};
        fork
            dbg_op(1'b0, 8'h90, 64'd0, SL * (L + 1) + L + 1, SL * (L + 1) + L + 1);
            begin
                for (int k = 0; k < 6; k++) begin
                    cpu_op(1'b0, 1'b1, 8'(8'h40 + k), 64'd0, lat5[k], lat5[k]);
                    if (dbg_pending) cpu_grants++;
                end
                cpu_idle();
            end
        join
        chk_rng("starve_cpu_grants", cpu_grants, SL, SL);
        repeat (2) @(posedge clock);

        // Simultaneous store and debug request: CPU first, DBG right after.
        fork
            begin
                cpu_op(1'b1, 1'b0, 8'h21, {$urandom, $urandom}, L, L);
                cpu_idle();
            end
            dbg_op(1'b0, 8'hA0, 64'd0, 2 * (L + 1), 2 * (L + 1));
        join
        repeat (2) @(posedge clock);

        // Reset during a debug write.
        @(posedge clock); #1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 64'hF0; dbg_wdata = 64'h1234;
        @(posedge clock); #1;
        reset = 1'b1;
        cpu_read = 1'b1; cpu_addr = 64'h10;
        @(negedge clock);
        chk1("reset_forces_no_stall", cpu_stall, 1'b0);
        @(posedge clock); #1;
        dbg_req = 1'b0; dbg_we = 1'b0; cpu_read = 1'b0;
        @(negedge clock);
        chk_outputs_zero("midreset");
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk1("no_ack_after_reset", dbg_ack, 1'b0);
        end
        cpu_op(1'b0, 1'b1, 8'h10, 64'd0, L, L);
        cpu_idle();

        // Randomized concurrent traffic on disjoint address regions.
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    int gap  = $urandom_range(0, 2);
                    int kind = $urandom_range(0, 9);
                    logic [7:0]    a = 8'($urandom_range(0, 127));
                    logic [DW-1:0] d = {$urandom, $urandom};
                    for (int g = 0; g < gap; g++) cpu_idle();
                    if (kind < 5)      cpu_op(1'b0, 1'b1, a, d, L, 2 * L + 1);
                    else if (kind < 8) cpu_op(1'b1, 1'b0, a, d, L, 2 * L + 1);
                    else               cpu_op(1'b1, 1'b1, a, d, L, 2 * L + 1);
                end
                cpu_idle();
            end
            begin
                for (int k = 0; k < 15; k++) begin
                    int gap = $urandom_range(0, 4);
                    logic [7:0]    a = 8'(8'h80 + $urandom_range(0, 47));
                    logic [DW-1:0] d = {$urandom, $urandom};
                    bit            we = 1'($urandom_range(0, 1));
                    for (int g = 0; g < gap; g++) @(posedge clock);
                    dbg_op(we, a, d, L + 1, (SL + 2) * (L + 1) + L + 1);
                end
            end
        join

        repeat (5) @(posedge clock);
        @(negedge clock);
        chk_rng("cpu_queue_drained", cpu_q.size(), 0, 0);
        chk_rng("dbg_queue_drained", dbg_q.size(), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port) used to preload and inspect memory.
- Sequences each access over MEM_LATENCY cycles and drives `cpu_stall` so the pipeline freezes while an access is outstanding.
- CPU has priority; a starvation counter guarantees DBG progress.
- Sits between the EX_MEM register outputs and the memory array; `cpu_rdata` feeds MEM_WB.

Parameters:
- DATA_WIDTH, 64, width of data and address buses.
- MEM_LATENCY, 2, cycles an access occupies memory (>=1).
- STARVE_LIMIT, 4, consecutive CPU grants allowed while `dbg_req` is pending before DBG is forced.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cpu_read  input  1  MEM stage load request (level)
- cpu_write  input  1  MEM stage store request (level)
- cpu_addr  input  DATA_WIDTH  access address
- cpu_wdata  input  DATA_WIDTH  store data
- cpu_rdata  output  DATA_WIDTH  load data to MEM_WB
- cpu_stall  output  1  freeze PC, IF_ID, ID_EX, EX_MEM
- dbg_req  input  1  debug request, held until `dbg_ack`
- dbg_we  input  1  1 = write, 0 = read
- dbg_addr  input  DATA_WIDTH  debug address
- dbg_wdata  input  DATA_WIDTH  debug write data
- dbg_rdata  output  DATA_WIDTH  debug read data
- dbg_ack  output  1  one-cycle completion pulse
- mem_en  output  1  memory enable
- mem_we  output  1  memory write enable
- mem_addr  output  DATA_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data, valid in final access cycle

Behaviour:
- Reset (synchronous, active-high): state IDLE, `cnt`=0, `starve_cnt`=0.
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_rdata` register, `dbg_rdata`, `dbg_ack` all 0.
  - `cpu_stall` is forced 0 while `reset`=1.
- States: IDLE, CPU_ACC, DBG_ACC.
- IDLE grant decision, in order:
  - `cpu_req` = `cpu_read` | `cpu_write`.
  - If `dbg_req` & `starve_cnt`==STARVE_LIMIT -> DBG.
  - Else if `cpu_req` -> CPU.
  - Else if `dbg_req` -> DBG.
  - Else stay IDLE with `mem_en`=0.
- On grant (edge leaving IDLE):
  - `mem_en`=1; `mem_we`/`mem_addr`/`mem_wdata` are registered from the winner; `cnt`=MEM_LATENCY-1.
  - The memory bus is held stable for the whole access.
- CPU with both `cpu_read` and `cpu_write` high: treated as a write.
- Access states: `cnt` decrements each cycle. The cycle with `cnt`==0 is the done cycle. The next edge returns to IDLE with `mem_en`=0, `mem_we`=0.
- `cpu_done` (combinational) = state==CPU_ACC & `cnt`==0.
  - `cpu_stall` = `cpu_req` & ~`cpu_done`.
  - `cpu_rdata` = `mem_rdata` during `cpu_done`; otherwise it holds the value registered at the last CPU done edge.
  - Per-access cost: MEM_LATENCY+1 cycles (1 IDLE + MEM_LATENCY). The stall is high for MEM_LATENCY cycles.
- DBG completion:
  - At the done edge, `dbg_rdata` is registered from `mem_rdata` (reads only; writes leave it unchanged).
  - `dbg_ack`=1 for exactly the following cycle.
  - A `dbg_req` still high in the `dbg_ack` cycle is treated as a new request.
- `starve_cnt`:
  - +1 on each CPU grant while `dbg_req`=1, saturating at STARVE_LIMIT.
  - Cleared on DBG grant, and on any cycle with `dbg_req`=0.
- CPU request arriving during DBG_ACC: stalled until the DBG access finishes and the CPU is granted.
- Requester inputs are sampled only at grant. Changes mid-access are ignored.
- Reset mid-access: the access is abandoned, no `dbg_ack`, `mem_en` drops next cycle. An in-flight write may or may not land; software re-issues it.

Test Plan:
- MEM_LATENCY=2, `cpu_read` @addr 0x10 with mem[0x10]=0xDEAD:
  - `cpu_stall` high for cycles 0 and 1, low in cycle 2.
  - `cpu_rdata`=0xDEAD in cycle 2.
  - `mem_en` high in cycles 1–2.
- `cpu_write` addr 0x20 data 0x55, then `cpu_read` 0x20 -> read returns 0x55. Two accesses take 6 cycles total.
- `dbg_req` read 0x30 (mem=0x7) with CPU idle -> DBG granted next cycle, `dbg_rdata`=0x7, single `dbg_ack` pulse 3 cycles after the request.
- CPU issuing back-to-back loads continuously plus `dbg_req` held, STARVE_LIMIT=4 -> exactly 4 CPU grants, then DBG granted. `cpu_stall` stays high through the DBG access, then CPU resumes.
- Simultaneous `cpu_write` and `dbg_req` in IDLE with `starve_cnt`=0 -> CPU wins, DBG granted immediately after; `starve_cnt`=1 before clearing.
- Reset asserted during cycle 1 of a DBG write -> no `dbg_ack`; after reset all outputs are 0 and state is IDLE; a fresh CPU read completes normally.
